// File: rtl/cmos_spi_cfg_seq.sv
// Table-driven CMOS sensor register configuration sequencer sitting in front of the SPI master.
// Walks the init table, issues one SPI transaction per entry, handles delays and write read-back verify.
module cmos_spi_cfg_seq #(
  parameter int unsigned TBL_AW    = 8,
  parameter int unsigned DLY_UNIT  = 1024,
  parameter bit          VERIFY    = 1'b1,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic              clk_input,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [TBL_AW-1:0] err_index,
  output logic [15:0]       err_rdata,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [25:0]       tbl_data,
  output logic [9:0]        command_address,
  output logic [15:0]       data_write,
  output logic              execute_pulse,
  input  logic              spi_idle_fd,
  input  logic [15:0]       data_read
);

  localparam int unsigned CMD_W = 10;
  localparam int unsigned DAT_W = 16;
  localparam int unsigned DLY_W = DAT_W + $clog2(DLY_UNIT) + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned RTY_W = 5;
  localparam logic [CMD_W-1:0]  CMD_END  = 10'h3FF;
  localparam logic [CMD_W-1:0]  CMD_DLY  = 10'h3FE;
  localparam logic [TBL_AW-1:0] IDX_LAST = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_VISSUE,
    S_VWAIT, S_DELAY, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t r_state, w_state_nxt;

  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_error, w_error_nxt;
  logic [TBL_AW-1:0] r_err_index, w_err_index_nxt;
  logic [DAT_W-1:0]  r_err_rdata, w_err_rdata_nxt;
  logic [TBL_AW-1:0] r_index, w_index_nxt;
  logic [CMD_W-1:0]  r_cmd, w_cmd_nxt;
  logic [DAT_W-1:0]  r_wdata, w_wdata_nxt;
  logic              r_exec, w_exec_nxt;
  logic              r_is_wr, w_is_wr_nxt;
  logic [3:0]        r_retry, w_retry_nxt;
  logic [TMO_W-1:0]  r_tmo_cnt, w_tmo_cnt_nxt;
  logic [DLY_W-1:0]  r_dly_cnt, w_dly_cnt_nxt;

  logic [CMD_W-1:0]  w_tbl_cmd;
  logic [DAT_W-1:0]  w_tbl_dat;
  logic              w_tmo_hit;
  logic              w_rd_match;
  logic              w_retry_ok;
  logic              w_restart;

  assign w_tbl_cmd  = tbl_data[25:16];
  assign w_tbl_dat  = tbl_data[15:0];
  assign w_tmo_hit  = (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign w_rd_match = (data_read == r_wdata);
  assign w_retry_ok = (RTY_W'(r_retry) + RTY_W'(1)) < RTY_W'(MAX_RETRY);
  assign w_restart  = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));

  // State register
  always_ff @(posedge clk_input or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (start) w_state_nxt = S_FETCH;
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (w_tbl_cmd == CMD_END)      w_state_nxt = S_DONE;
        else if (w_tbl_cmd == CMD_DLY) w_state_nxt = S_DELAY;
        else                           w_state_nxt = S_ISSUE;
      end
      S_ISSUE:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (spi_idle_fd)    w_state_nxt = (r_is_wr && VERIFY) ? S_VISSUE : S_NEXT;
        else if (w_tmo_hit) w_state_nxt = S_ERROR;
      end
      S_VISSUE: w_state_nxt = S_VWAIT;
      S_VWAIT: begin
        if (spi_idle_fd) begin
          if (w_rd_match)      w_state_nxt = S_NEXT;
          else if (w_retry_ok) w_state_nxt = S_ISSUE;
          else                 w_state_nxt = S_ERROR;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_ERROR;
        end
      end
      // The decode cycle counts as the first delay cycle, so the count stops at 2
      S_DELAY:  if (r_dly_cnt <= DLY_W'(2)) w_state_nxt = S_NEXT;
      S_NEXT:   w_state_nxt = (r_index == IDX_LAST) ? S_DONE : S_FETCH;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    w_busy_nxt      = r_busy;
    w_done_nxt      = r_done;
    w_error_nxt     = r_error;
    w_err_index_nxt = r_err_index;
    w_err_rdata_nxt = r_err_rdata;
    w_index_nxt     = r_index;
    w_cmd_nxt       = r_cmd;
    w_wdata_nxt     = r_wdata;
    w_is_wr_nxt     = r_is_wr;
    w_retry_nxt     = r_retry;
    w_tmo_cnt_nxt   = r_tmo_cnt;
    w_dly_cnt_nxt   = r_dly_cnt;
    w_exec_nxt      = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_VISSUE);

    if (w_restart) begin
      w_busy_nxt      = 1'b1;
      w_done_nxt      = 1'b0;
      w_error_nxt     = 1'b0;
      w_err_rdata_nxt = '0;
      w_index_nxt     = '0;
    end

    case (r_state)
      S_DECODE: begin
        if (w_tbl_cmd == CMD_DLY) begin
          w_dly_cnt_nxt = DLY_W'(w_tbl_dat) * DLY_W'(DLY_UNIT);
        end else if (w_tbl_cmd != CMD_END) begin
          w_cmd_nxt   = w_tbl_cmd;
          w_wdata_nxt = w_tbl_dat;
          w_is_wr_nxt = w_tbl_cmd[0];
          w_retry_nxt = '0;
        end
      end
      S_WAIT: if (spi_idle_fd && r_is_wr && VERIFY) w_cmd_nxt = {r_cmd[CMD_W-1:1], 1'b0};
      S_VWAIT: begin
        if (spi_idle_fd) begin
          w_err_rdata_nxt = data_read;
          if (!w_rd_match && w_retry_ok) begin
            w_retry_nxt = r_retry + 4'd1;
            w_cmd_nxt   = {r_cmd[CMD_W-1:1], 1'b1};
          end
        end
      end
      S_DELAY: if (r_dly_cnt > DLY_W'(2)) w_dly_cnt_nxt = r_dly_cnt - DLY_W'(1);
      S_NEXT:  if (r_index != IDX_LAST) w_index_nxt = r_index + TBL_AW'(1);
      default: ;
    endcase

    // Timeout window runs from the pulse cycle through the wait state
    if ((w_state_nxt == S_ISSUE) || (w_state_nxt == S_VISSUE)) begin
      w_tmo_cnt_nxt = '0;
    end else if ((r_state == S_ISSUE) || (r_state == S_WAIT) ||
                 (r_state == S_VISSUE) || (r_state == S_VWAIT)) begin
      w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
    end

    if (w_state_nxt == S_DONE && !w_restart) begin
      w_done_nxt = 1'b1;
      w_busy_nxt = 1'b0;
    end
    if (w_state_nxt == S_ERROR && r_state != S_ERROR) begin
      w_error_nxt     = 1'b1;
      w_busy_nxt      = 1'b0;
      w_err_index_nxt = r_index;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_input or posedge reset) begin
    if (reset) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_index <= '0;
      r_err_rdata <= '0;
      r_index     <= '0;
      r_cmd       <= '0;
      r_wdata     <= '0;
      r_exec      <= 1'b0;
      r_is_wr     <= 1'b0;
      r_retry     <= '0;
      r_tmo_cnt   <= '0;
      r_dly_cnt   <= '0;
    end else begin
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
      r_err_index <= w_err_index_nxt;
      r_err_rdata <= w_err_rdata_nxt;
      r_index     <= w_index_nxt;
      r_cmd       <= w_cmd_nxt;
      r_wdata     <= w_wdata_nxt;
      r_exec      <= w_exec_nxt;
      r_is_wr     <= w_is_wr_nxt;
      r_retry     <= w_retry_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
      r_dly_cnt   <= w_dly_cnt_nxt;
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign error           = r_error;
  assign err_index       = r_err_index;
  assign err_rdata       = r_err_rdata;
  assign tbl_addr        = r_index;
  assign command_address = r_cmd;
  assign data_write      = r_wdata;
  assign execute_pulse   = r_exec;

endmodule

// File: tb/tb_cmos_spi_cfg_seq.sv
// Bench for cmos_spi_cfg_seq: table ROM, SPI master responder with register file, and a
// table-walking reference model that predicts the transaction stream and final status.
module tb_cmos_spi_cfg_seq;

  localparam int unsigned TBL_AW    = 8;
  localparam int unsigned DLY_UNIT  = 1024;
  localparam bit          VERIFY    = 1'b1;
  localparam int unsigned MAX_RETRY = 3;
  localparam int unsigned TIMEOUT   = 4096;
  localparam int          DEPTH     = 1 << TBL_AW;

  typedef struct packed {
    logic [9:0]  cmd;
    logic [15:0] data;
  } txn_t;

  logic              clk_input = 1'b0;
  logic              reset;
  logic              start;
  logic              busy, done, error;
  logic [TBL_AW-1:0] err_index;
  logic [15:0]       err_rdata;
  logic [TBL_AW-1:0] tbl_addr;
  logic [25:0]       tbl_data;
  logic [9:0]        command_address;
  logic [15:0]       data_write;
  logic              execute_pulse;
  logic              spi_idle_fd;
  logic [15:0]       data_read;

  logic [25:0] tbl   [DEPTH];
  logic [15:0] sregs [512];
  logic [15:0] mref  [512];
  txn_t        obs_q [$];
  txn_t        exp_q [$];

  int          n_checks  = 0;
  int          n_errors  = 0;
  int          cyc       = 0;
  int          lat       = 4;
  int          bad_left  = 0;
  int          pulse_cyc = 0;
  bit          no_resp   = 0;
  bit          flush_req = 0;
  bit          spur_en   = 0;
  logic [15:0] bad_xor   = 16'h0004;

  bit              exp_done, exp_err;
  logic [TBL_AW-1:0] exp_eidx;
  logic [15:0]     exp_erd;

  cmos_spi_cfg_seq #(
    .TBL_AW(TBL_AW), .DLY_UNIT(DLY_UNIT), .VERIFY(VERIFY),
    .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk_input(clk_input), .reset(reset), .start(start),
    .busy(busy), .done(done), .error(error),
    .err_index(err_index), .err_rdata(err_rdata),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .command_address(command_address), .data_write(data_write),
    .execute_pulse(execute_pulse), .spi_idle_fd(spi_idle_fd), .data_read(data_read)
  );

  always #5 clk_input = ~clk_input;

  // Synchronous table ROM: data valid one cycle after the address
  always @(posedge clk_input) tbl_data <= tbl[tbl_addr];

  initial forever begin
    @(posedge clk_input);
    cyc++;
  end

  // SPI master model: one outstanding transaction, answers lat cycles after the pulse
  initial begin : responder
    int          cnt;
    bit          pend;
    logic [9:0]  pc;
    logic [15:0] pd, rd;
    pend = 0; cnt = 0; pc = '0; pd = '0;
    spi_idle_fd = 1'b0;
    data_read   = '0;
    forever begin
      @(posedge clk_input);
      #1;
      spi_idle_fd = 1'b0;
      if (reset || flush_req) begin
        pend = 0;
        flush_req = 0;
      end else if (execute_pulse) begin
        n_checks++;
        if (pend) begin
          n_errors++;
          $display("FAIL overlap: execute_pulse=1 with a transaction outstanding (cmd %h)", command_address);
        end
        pend = 1; cnt = lat; pc = command_address; pd = data_write; pulse_cyc = cyc;
        obs_q.push_back({pc, pd});
        if (pc[0]) sregs[pc[9:1]] = pd;
      end else if (pend) begin
        if (!no_resp) begin
          cnt--;
          if (cnt <= 0) begin
            n_checks++;
            if (command_address !== pc || data_write !== pd) begin
              n_errors++;
              $display("FAIL bus_stable: got %h/%h required %h/%h", command_address, data_write, pc, pd);
            end
            if (pc[0]) begin
              rd = 16'($urandom);
            end else begin
              rd = sregs[pc[9:1]];
              if (bad_left > 0) begin
                rd = rd ^ bad_xor;
                bad_left--;
              end
            end
            data_read = rd;
            spi_idle_fd = 1'b1;
            pend = 0;
          end
        end
      end else if (spur_en && $urandom_range(0, 15) == 0) begin
        data_read = 16'($urandom);
        spi_idle_fd = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_input);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic clear_table();
    for (int i = 0; i < DEPTH; i++) tbl[i] = {10'h3FF, 16'h0000};
  endtask

  task automatic wait_end(input int budget, input string name);
    int n;
    n = 0;
    while (!(done || error) && n < budget) begin
      tick(1);
      n++;
    end
    n_checks++;
    if (!(done || error)) begin
      n_errors++;
      $display("FAIL %s_end: no done/error after %0d cycles, required within budget", name, budget);
    end
  endtask

  // Reference: walk the table by its rules and list the transactions the master should see
  task automatic ref_model(input int bad_in);
    int          bad;
    bit          ok;
    logic [9:0]  c;
    logic [15:0] d, rd;
    bad = bad_in;
    for (int k = 0; k < 512; k++) mref[k] = sregs[k];
    exp_q.delete();
    exp_done = 0; exp_err = 0; exp_eidx = '0; exp_erd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = tbl[i][25:16];
      d = tbl[i][15:0];
      if (c == 10'h3FF) begin
        exp_done = 1;
        return;
      end
      if (c == 10'h3FE) continue;
      if (!c[0]) begin
        exp_q.push_back({c, d});
        if (bad > 0) bad--;
        continue;
      end
      ok = 0;
      for (int a = 0; a < int'(MAX_RETRY) && !ok; a++) begin
        exp_q.push_back({c, d});
        mref[c[9:1]] = d;
        if (!VERIFY) begin
          ok = 1;
        end else begin
          exp_q.push_back({{c[9:1], 1'b0}, d});
          rd = mref[c[9:1]];
          if (bad > 0) begin
            rd = rd ^ bad_xor;
            bad--;
          end
          exp_erd = rd;
          ok = (rd == d);
        end
      end
      if (!ok) begin
        exp_err = 1;
        exp_eidx = TBL_AW'(i);
        return;
      end
    end
    exp_done = 1;
  endtask

  task automatic check_result(input string name);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL %s_count: got %0d transactions required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin
        n_errors++;
        $display("FAIL %s_txn%0d: got %h/%h required %h/%h", name, k,
                 obs_q[k].cmd, obs_q[k].data, exp_q[k].cmd, exp_q[k].data);
      end
    end
    n_checks++;
    if (done !== exp_done || error !== exp_err || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_status: got done=%b error=%b busy=%b required %b/%b/0", name, done, error, busy, exp_done, exp_err);
    end
    n_checks++;
    if (err_rdata !== exp_erd) begin
      n_errors++;
      $display("FAIL %s_err_rdata: got %h required %h", name, err_rdata, exp_erd);
    end
    if (exp_err) begin
      n_checks++;
      if (err_index !== exp_eidx) begin
        n_errors++;
        $display("FAIL %s_err_index: got %0d required %0d", name, err_index, exp_eidx);
      end
    end
  endtask

  task automatic test_reset();
    tick(1);
    n_checks++;
    if ({busy, done, error, execute_pulse} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags: got busy/done/error/pulse=%b required 0000", {busy, done, error, execute_pulse});
    end
    n_checks++;
    if (err_index !== '0 || err_rdata !== '0 || tbl_addr !== '0) begin
      n_errors++;
      $display("FAIL reset_idx: got err_index=%h err_rdata=%h tbl_addr=%h required 0", err_index, err_rdata, tbl_addr);
    end
    n_checks++;
    if (command_address !== '0 || data_write !== '0) begin
      n_errors++;
      $display("FAIL reset_bus: got %h/%h required 0/0", command_address, data_write);
    end
    reset = 1'b0;
    tick(3);
    n_checks++;
    if ({busy, done, error, execute_pulse} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_idle: got %b required 0000", {busy, done, error, execute_pulse});
    end
  endtask

  task automatic run_directed(input string name, input int bad);
    bad_left = bad;
    obs_q.delete();
    ref_model(bad);
    pulse_start();
    wait_end(20000, name);
    tick(2);
    check_result(name);
    bad_left = 0;
  endtask

  task automatic test_write_verify();
    clear_table();
    tbl[0] = {10'h201, 16'h1234};
    lat = 40; bad_xor = 16'h0004;
    run_directed("wr_verify", 0);
    n_checks++;
    if (obs_q.size() != 2 || obs_q[1].cmd !== 10'h200 || obs_q[0] !== {10'h201, 16'h1234}) begin
      n_errors++;
      $display("FAIL wr_verify_fixed: got %0d txns, required 201/1234 then 200", obs_q.size());
    end
    n_checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      n_errors++;
      $display("FAIL wr_verify_done: got done=%b error=%b required 1/0", done, error);
    end
  endtask

  task automatic test_retry();
    clear_table();
    tbl[0] = {10'h201, 16'h1234};
    lat = 6; bad_xor = 16'h0004;
    run_directed("retry_ok", 2);
    n_checks++;
    if (obs_q.size() != 6 || done !== 1'b1 || err_rdata !== 16'h1234) begin
      n_errors++;
      $display("FAIL retry_ok_fixed: got %0d txns done=%b rdata=%h required 6/1/1234", obs_q.size(), done, err_rdata);
    end
    run_directed("retry_fail", 1000);
    n_checks++;
    if (obs_q.size() != 6 || error !== 1'b1 || err_index !== '0 || err_rdata !== 16'h1230) begin
      n_errors++;
      $display("FAIL retry_fail_fixed: got %0d txns error=%b idx=%0d rdata=%h required 6/1/0/1230",
               obs_q.size(), error, err_index, err_rdata);
    end
  endtask

  task automatic test_delay();
    int s;
    clear_table();
    tbl[0] = {10'h3FE, 16'h0002};
    obs_q.delete();
    pulse_start();
    s = cyc;
    wait_end(3000, "delay");
    n_checks++;
    if (cyc - s < 2044 || cyc - s > 2052 || done !== 1'b1) begin
      n_errors++;
      $display("FAIL delay_time: got done=%b after %0d cycles required 1 within 2048+-4", done, cyc - s);
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_errors++;
      $display("FAIL delay_pulses: got %0d transactions required 0", obs_q.size());
    end
  endtask

  task automatic test_timeout();
    clear_table();
    tbl[0] = {10'h201, 16'h1234};
    obs_q.delete();
    no_resp = 1;
    pulse_start();
    wait_end(TIMEOUT + 200, "timeout");
    n_checks++;
    if (error !== 1'b1 || cyc - pulse_cyc != int'(TIMEOUT) || err_index !== '0) begin
      n_errors++;
      $display("FAIL timeout_err: got error=%b %0d cycles after pulse idx=%0d required 1 at %0d idx 0",
               error, cyc - pulse_cyc, err_index, TIMEOUT);
    end
    n_checks++;
    if (busy !== 1'b0 || obs_q.size() != 1) begin
      n_errors++;
      $display("FAIL timeout_state: got busy=%b txns=%0d required 0/1", busy, obs_q.size());
    end
    no_resp = 0; flush_req = 1; lat = 3;
    tick(2);
    obs_q.delete();
    ref_model(0);
    pulse_start();
    n_checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_restart: got error=%b busy=%b required 0/1", error, busy);
    end
    wait_end(2000, "timeout_rerun");
    tick(2);
    check_result("timeout_rerun");
  endtask

  task automatic test_reset_mid();
    int n;
    clear_table();
    tbl[0] = {10'h201, 16'h1234};
    lat = 40;
    obs_q.delete();
    pulse_start();
    n = 0;
    while (obs_q.size() == 0 && n < 20) begin
      tick(1);
      n++;
    end
    tick(5);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, error, execute_pulse} !== 4'b0000 || command_address !== '0 || tbl_addr !== '0) begin
      n_errors++;
      $display("FAIL reset_mid: got busy/done/error/pulse=%b cmd=%h addr=%h required 0000/0/0",
               {busy, done, error, execute_pulse}, command_address, tbl_addr);
    end
    tick(2);
    reset = 1'b0;
    tick(80);
    n_checks++;
    if (obs_q.size() != 1 || busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_quiet: got txns=%0d busy=%b done=%b required 1/0/0", obs_q.size(), busy, done);
    end
  endtask

  task automatic test_table_end();
    clear_table();
    for (int i = 0; i < DEPTH; i++) tbl[i] = {9'($urandom_range(0, 510)), 1'b0, 16'($urandom)};
    lat = 1;
    run_directed("table_end", 0);
  endtask

  task automatic test_random();
    int  len, r;
    bit  long_used;
    for (int it = 0; it < 8; it++) begin
      clear_table();
      long_used = 0;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        if (r <= 4)      tbl[i] = {9'($urandom_range(0, 510)), 1'b1, 16'($urandom)};
        else if (r <= 7) tbl[i] = {9'($urandom_range(0, 510)), 1'b0, 16'($urandom)};
        else begin
          tbl[i] = {10'h3FE, (r == 9 && !long_used) ? 16'h0001 : 16'h0000};
          if (r == 9) long_used = 1;
        end
      end
      lat = $urandom_range(1, 12);
      bad_xor = 16'($urandom_range(1, 65535));
      bad_left = $urandom_range(0, 4);
      obs_q.delete();
      ref_model(bad_left);
      spur_en = 1;
      pulse_start();
      tick($urandom_range(2, 30));
      if (busy) begin
        start = 1'b1;
        tick(1);
        start = 1'b0;
      end
      wait_end(20000, "random");
      spur_en = 0;
      tick(2);
      check_result($sformatf("random%0d", it));
      bad_left = 0;
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear_table();
    for (int k = 0; k < 512; k++) sregs[k] = 16'($urandom);
    test_reset();
    test_write_verify();
    test_retry();
    test_delay();
    test_timeout();
    test_reset_mid();
    test_table_end();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
